spi_peripheral: RTL and testbench
=================================

# spi_peripheral

SPI slave (mode 0, CPOL=0/CPHA=0, MSB first) that lets an external controller write command bytes into the GPU/VGA core and read back a 32-bit configuration word. External SPI pins are oversampled in the system clock domain. The received byte is presented to downstream logic on `recieved_data`.

## Interface
- `FRAME_BITS`, default 8: bits per SPI byte. Fixed at 8.
- `CFG_BYTES`, default 4: number of bytes in `config_data`.
- `clk`, input, 1: system clock. All internal state runs on its rising edge.
- `rst_n`, input, 1: asynchronous, active-high reset. The name is kept for codebase compatibility; asserting it high resets the block.
- `ss`, input, 1: slave select, active low. Asynchronous to `clk`.
- `sclk`, input, 1: SPI clock, idle low. Asynchronous to `clk`.
- `mosi`, input, 1: controller-to-peripheral data.
- `miso`, output, 1: peripheral-to-controller data. Driven 0 when not selected; never tri-stated.
- `config_data`, input, 32: word returned to the controller, byte-serialised.
- `recieved_data`, output, 8: last complete byte received. The misspelling is the port name.

## Operation
- Synchronisers:
  - `ss`, `sclk` and `mosi` each pass through a 2-FF synchroniser.
  - A third `sclk` stage detects edges: rise = sync & ~prev, fall = ~sync & prev.
- Transaction start:
  - Synchronised `ss` falling edge clears the bit counter (0..7) and the byte index (0..3).
  - It loads the TX shift register with `config_data[7:0]` and drives its bit 7 on `miso`.
- On each `sclk` rise while selected:
  - Shift synchronised `mosi` into the RX shift register from the LSB side.
  - Increment the bit counter.
- On the 8th rise:
  - Write {rx[6:0], mosi} to `recieved_data`. It holds until the next complete byte.
  - Wrap the bit counter to 0.
  - Increment the byte index modulo 4.
- On each `sclk` fall while selected:
  - If a byte just completed, load TX with `config_data[8*idx +: 8]` (sampled at that cycle) and drive its bit 7.
  - Otherwise shift TX left and drive the new bit 7.
- Byte order: byte k of a transaction returns `config_data` byte (k mod 4), least-significant byte first. Bits within each byte go MSB first.
- Early `ss` release: if `ss` rises before 8 bits, the partial RX byte is discarded and `recieved_data` is unchanged. `miso` returns to 0.
- `sclk` edges while `ss` is high are ignored.
- Reset values: `recieved_data` = 0x00, `miso` = 0, counters 0, shift registers 0, synchroniser flops at idle (`ss`=1, `sclk`=0, `mosi`=0). Reset mid-transaction aborts it; the controller must re-assert `ss`.

## Timing
- Input-to-internal latency is 2 `clk` cycles. An edge is detected on the 3rd `clk` edge after the pin change.
- Each `sclk` high and low phase must last at least 1 `clk` period, so `sclk` ≤ `clk`/2.
- `mosi` must be stable from 1 `clk` before until 3 `clk` after `sclk` rise.
- `miso` is registered. It updates 3 `clk` cycles after the `sclk` fall, or after the `ss` fall for the first bit, so the controller gets about ½ `sclk` period of setup minus 3 `clk`.
- `ss` must be low at least 3 `clk` cycles before the first `sclk` rise.
- `recieved_data` updates 3 `clk` cycles after the 8th `sclk` rise.
- `ss` rising in the same `clk` cycle as a detected `sclk` rise: deselect wins and the bit is not captured.

## Structure
- Shared package `spi_pkg`: `FRAME_BITS`, `CFG_BYTES`, reset constants (`SS_IDLE`=1, `SCLK_IDLE`=0).
- One sub-module, `sync_edge`: parameterised 2-FF synchroniser with rise/fall outputs. Instantiated for `sclk` and `ss`; `mosi` uses sync only.
- Top level holds the bit/byte counters and the RX/TX shift registers.

## Test plan
- Reset: assert `rst_n`=1 mid-idle -> `recieved_data`=0x00 and `miso`=0 immediately; release -> unchanged.
- Write: `ss` low, shift 0x8F MSB first with `sclk` half-period 10 ns, `clk` 10 ns -> `recieved_data`=0x8F 3 cycles after the 8th rise.
- Readback: `config_data`=0xDEADBEEF; two bytes while sending 0x00 -> `miso` returns 0xEF then 0xBE; `recieved_data`=0x00.
- Wrap: 5 bytes in one transaction with `config_data`=0x44332211 -> `miso` returns 0x11, 0x22, 0x33, 0x44, 0x11.
- Abort: send 5 bits of 0xA5 then raise `ss` -> `recieved_data` keeps its prior value; next full byte 0x3C -> 0x3C.
- Deselected: toggle `sclk` 16 times with `ss`=1 and `mosi`=1 -> no change, `miso`=0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for the SPI peripheral: frame geometry and pin idle levels.
package spi_pkg;

    localparam int unsigned FRAME_BITS = 8;
    localparam int unsigned CFG_BYTES  = 4;

    localparam logic SS_IDLE   = 1'b1;
    localparam logic SCLK_IDLE = 1'b0;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus a third stage for edge detection.
module sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise_c,
    output logic fall_c
);

    logic meta;
    logic prev;

    // rst_n is active high; it parks the chain at the pin's idle level
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise_c = sync & ~prev;
    assign fall_c = ~sync & prev;

endmodule

// File: rtl/spi_peripheral.sv
// Mode-0 SPI slave: captures command bytes from mosi and streams config_data
// back on miso, least-significant byte first, MSB first within each byte.
module spi_peripheral #(
    parameter int unsigned FRAME_BITS = spi_pkg::FRAME_BITS,
    parameter int unsigned CFG_BYTES  = spi_pkg::CFG_BYTES
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ss,
    input  logic                             sclk,
    input  logic                             mosi,
    output logic                             miso,
    input  logic [FRAME_BITS*CFG_BYTES-1:0]  config_data,
    output logic [FRAME_BITS-1:0]            recieved_data
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS);
    localparam int unsigned IDX_W = $clog2(CFG_BYTES);

    logic ss_sync;
    logic ss_rise;
    logic ss_fall;
    logic sclk_sync;
    logic sclk_rise;
    logic sclk_fall;
    logic mosi_meta;
    logic mosi_sync;

    logic [CNT_W-1:0]      bit_cnt;
    logic [IDX_W-1:0]      byte_idx;
    logic                  byte_done;
    logic [FRAME_BITS-1:0] rx;
    logic [FRAME_BITS-1:0] tx;
    logic [FRAME_BITS-1:0] rx_next;

    logic [CFG_BYTES-1:0][FRAME_BITS-1:0] cfg_bytes;

    sync_edge #(.RESET_VAL(spi_pkg::SS_IDLE)) u_ss_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (ss),
        .sync   (ss_sync),
        .rise_c (ss_rise),
        .fall_c (ss_fall)
    );

    sync_edge #(.RESET_VAL(spi_pkg::SCLK_IDLE)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (sclk),
        .sync   (sclk_sync),
        .rise_c (sclk_rise),
        .fall_c (sclk_fall)
    );

    // mosi only needs its level, sampled in step with the sclk chain
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
        end
    end

    assign cfg_bytes = config_data;
    assign rx_next   = {rx[FRAME_BITS-2:0], mosi_sync};

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            bit_cnt       <= '0;
            byte_idx      <= '0;
            byte_done     <= 1'b0;
            rx            <= '0;
            tx            <= '0;
            miso          <= 1'b0;
            recieved_data <= '0;
        end else if (ss_fall) begin
            bit_cnt   <= '0;
            byte_idx  <= '0;
            byte_done <= 1'b0;
            rx        <= '0;
            tx        <= cfg_bytes[0];
            miso      <= cfg_bytes[0][FRAME_BITS-1];
        end else if (ss_rise) begin
            // deselect discards any partial byte and wins over a coincident sclk edge
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            rx        <= '0;
            miso      <= 1'b0;
        end else if (!ss_sync) begin
            if (sclk_rise) begin
                rx <= rx_next;
                if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                    recieved_data <= rx_next;
                    bit_cnt       <= '0;
                    byte_idx      <= (byte_idx == IDX_W'(CFG_BYTES - 1)) ? '0
                                                                         : byte_idx + IDX_W'(1);
                    byte_done     <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end else if (sclk_fall && !sclk_sync) begin
                if (byte_done) begin
                    tx        <= cfg_bytes[byte_idx];
                    miso      <= cfg_bytes[byte_idx][FRAME_BITS-1];
                    byte_done <= 1'b0;
                end else begin
                    tx   <= {tx[FRAME_BITS-2:0], 1'b0};
                    miso <= tx[FRAME_BITS-2];
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: write, readback, byte wrap, abort, deselected sclk, reset.
module tb_spi_peripheral;

    logic        clk;
    logic        rst_n;
    logic        ss;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic [31:0] config_data;
    logic [7:0]  recieved_data;

    int total;
    int bad;

    logic [7:0] got;
    logic [7:0] wrap_exp [5];

    spi_peripheral dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ss            (ss),
        .sclk          (sclk),
        .mosi          (mosi),
        .miso          (miso),
        .config_data   (config_data),
        .recieved_data (recieved_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift nbits of data MSB first; miso is sampled just before each sclk rise.
    task automatic spi_bits(input logic [7:0] data, input int nbits, input int half,
                            output logic [7:0] rx);
        logic [7:0] d;
        d  = data;
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = d[7];
            d    = d << 1;
            tick(half);
            rx   = {rx[6:0], miso};
            sclk = 1'b1;
            tick(half);
            sclk = 1'b0;
        end
    endtask

    task automatic select;
        ss = 1'b0;
        tick(4);
    endtask

    task automatic deselect;
        tick(2);
        ss = 1'b1;
        tick(4);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b1;
        ss          = 1'b1;
        sclk        = 1'b0;
        mosi        = 1'b0;
        config_data = 32'h0;
        wrap_exp[0] = 8'h11;
        wrap_exp[1] = 8'h22;
        wrap_exp[2] = 8'h33;
        wrap_exp[3] = 8'h44;
        wrap_exp[4] = 8'h11;

        // power-on reset
        tick(1);
        check("rst_rdata", recieved_data, 8'h00);
        check("rst_miso", miso, 1'b0);
        tick(2);
        rst_n = 1'b0;
        tick(3);
        check("post_rst_rdata", recieved_data, 8'h00);
        check("post_rst_miso", miso, 1'b0);

        // write 0x8F with sclk half-period of one clk; observe the 3-cycle latency
        select;
        spi_bits(8'h8F, 8, 1, got);
        check("wr_1clk", recieved_data, 8'h00);
        tick(1);
        check("wr_2clk", recieved_data, 8'h00);
        tick(1);
        check("wr_3clk", recieved_data, 8'h8F);
        deselect;
        check("wr_hold", recieved_data, 8'h8F);

        // readback of the low two bytes while writing zeros
        config_data = 32'hDEADBEEF;
        select;
        spi_bits(8'h00, 8, 5, got);
        check("rd_byte0", got, 8'hEF);
        spi_bits(8'h00, 8, 5, got);
        check("rd_byte1", got, 8'hBE);
        tick(4);
        check("rd_rdata", recieved_data, 8'h00);
        deselect;
        check("rd_miso_idle", miso, 1'b0);

        // five bytes in one transaction: byte index wraps back to byte 0
        config_data = 32'h44332211;
        select;
        for (int k = 0; k < 5; k++) begin
            spi_bits(8'(k + 1), 8, 5, got);
            check($sformatf("wrap_byte%0d", k), got, wrap_exp[k]);
        end
        tick(4);
        check("wrap_rdata", recieved_data, 8'h05);
        deselect;

        // abort after 5 bits: partial byte dropped, next full byte lands cleanly
        select;
        spi_bits(8'hA5, 5, 5, got);
        deselect;
        check("abort_rdata", recieved_data, 8'h05);
        check("abort_miso", miso, 1'b0);
        select;
        spi_bits(8'h3C, 8, 5, got);
        check("after_abort_miso", got, 8'h11);
        tick(4);
        check("after_abort_rdata", recieved_data, 8'h3C);
        deselect;

        // sclk activity while deselected is ignored
        mosi = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sclk = ~sclk;
            tick(2);
            check($sformatf("desel_miso%0d", i), miso, 1'b0);
        end
        tick(4);
        check("desel_rdata", recieved_data, 8'h3C);

        // asynchronous reset mid-idle clears the received byte without waiting for clk
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("async_rst_rdata", recieved_data, 8'h00);
        check("async_rst_miso", miso, 1'b0);
        tick(2);
        rst_n = 1'b0;
        tick(2);
        check("rst_release_rdata", recieved_data, 8'h00);
        check("rst_release_miso", miso, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
